// File: rtl/sys_out_collector.sv
// sys_out_collector: receive end of the systolic array's bottom edge.
//
// Column 1 delivers the element of row r one cycle before column 2 does. The
// column-1 value is parked in a pending register until its column-2 partner
// arrives, then the pair is pushed into a row FIFO. Rows leave on a
// valid/ready stream with job accounting (out_last, done). The array cannot
// be stalled, so pairing violations and FIFO overflow are only flagged.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, cfg_rows          start pulse and row count of the job
//   col_data_in_1/2          column outputs from the array
//   col_valid_in_1/2         matching valids
//   out_data_0/1             row elements (column 1, column 2)
//   out_valid/out_ready      row stream handshake
//   out_last                 presented row is the job's final row
//   busy, done               job in progress / final row accepted (pulse)
//   fifo_count               rows currently stored
//   err_align, err_overflow  sticky error flags
module sys_out_collector #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ROWS_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ROWS_W-1:0]        cfg_rows,
  input  logic [DATA_W-1:0]        col_data_in_1,
  input  logic                     col_valid_in_1,
  input  logic [DATA_W-1:0]        col_data_in_2,
  input  logic                     col_valid_in_2,
  output logic [DATA_W-1:0]        out_data_0,
  output logic [DATA_W-1:0]        out_data_1,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     err_align,
  output logic                     err_overflow
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StCollect, StDrain} state_e;

  state_e              state_q, state_d;
  logic [ROWS_W-1:0]   rows_in_q, rows_in_d;
  logic [ROWS_W-1:0]   rows_out_q, rows_out_d;
  logic                pend_q, pend_d;
  logic [DATA_W-1:0]   pend_data_q, pend_data_d;
  logic                err_align_q, err_align_d;
  logic                err_ovf_q, err_ovf_d;
  logic                done_q, done_d;

  logic [2*DATA_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]     count_q, count_d;

  logic                push_req, push_ok, drop, pop, full;

  assign out_valid = (count_q != '0);
  assign full      = (count_q == CntW'(DEPTH));
  assign pop       = out_valid && out_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok   = push_req && (!full || pop);
  assign drop      = push_req && full && !pop;

  always_comb begin
    state_d     = state_q;
    rows_in_d   = rows_in_q;
    rows_out_d  = rows_out_q;
    pend_d      = pend_q;
    pend_data_d = pend_data_q;
    err_align_d = err_align_q;
    err_ovf_d   = err_ovf_q;
    done_d      = 1'b0;
    push_req    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          err_align_d = 1'b0;
          err_ovf_d   = 1'b0;
          pend_d      = 1'b0;
          if (cfg_rows != '0) begin
            rows_in_d  = cfg_rows;
            rows_out_d = cfg_rows;
            state_d    = StCollect;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StCollect: begin
        if (col_valid_in_2) begin
          if (pend_q) push_req = 1'b1;
          else        err_align_d = 1'b1;
        end
        if (col_valid_in_1) begin
          // Column 1 arriving while still waiting on column 2 loses a row.
          if (pend_q && !col_valid_in_2) err_align_d = 1'b1;
          pend_d      = 1'b1;
          pend_data_d = col_data_in_1;
        end else if (push_req) begin
          pend_d = 1'b0;
        end
        if (push_req) begin
          rows_in_d = rows_in_q - ROWS_W'(1);
          if (rows_in_q == ROWS_W'(1)) begin
            state_d = StDrain;
            pend_d  = 1'b0;
          end
        end
      end
      StDrain: begin
        if (pop && rows_out_q == ROWS_W'(1)) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Dropped rows are counted as delivered so the job still terminates.
    if (state_q != StIdle && (pop || drop)) rows_out_d = rows_out_q - ROWS_W'(1);
    if (drop) err_ovf_d = 1'b1;

    count_d = count_q + CntW'(push_ok) - CntW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      rows_in_q   <= '0;
      rows_out_q  <= '0;
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      err_align_q <= 1'b0;
      err_ovf_q   <= 1'b0;
      done_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      rows_in_q   <= rows_in_d;
      rows_out_q  <= rows_out_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      err_align_q <= err_align_d;
      err_ovf_q   <= err_ovf_d;
      done_q      <= done_d;
      count_q     <= count_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem_q[wr_ptr_q] <= {pend_data_q, col_data_in_2};
  end

  assign out_data_0   = out_valid ? mem_q[rd_ptr_q][2*DATA_W-1:DATA_W] : '0;
  assign out_data_1   = out_valid ? mem_q[rd_ptr_q][DATA_W-1:0] : '0;
  assign out_last     = out_valid && (rows_out_q == ROWS_W'(1));
  assign busy         = (state_q != StIdle);
  assign done         = done_q;
  assign fifo_count   = count_q;
  assign err_align    = err_align_q;
  assign err_overflow = err_ovf_q;

endmodule

// File: tb/tb_sys_out_collector.sv
// Bench for sys_out_collector: expected rows are queued as column data is
// driven and compared when the DUT hands them over on the output stream.
module tb_sys_out_collector;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  cfg_rows;
  logic [15:0] col_data_in_1;
  logic        col_valid_in_1;
  logic [15:0] col_data_in_2;
  logic        col_valid_in_2;
  logic [15:0] out_data_0;
  logic [15:0] out_data_1;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        done;
  logic [3:0]  fifo_count;
  logic        err_align;
  logic        err_overflow;

  typedef struct packed {
    logic [15:0] d0;
    logic [15:0] d1;
    logic        last;
  } row_t;

  row_t sb[$];
  int   total;
  int   bad;
  logic zero_start;

  sys_out_collector #(
    .DATA_W (16),
    .DEPTH  (8),
    .ROWS_W (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .cfg_rows       (cfg_rows),
    .col_data_in_1  (col_data_in_1),
    .col_valid_in_1 (col_valid_in_1),
    .col_data_in_2  (col_data_in_2),
    .col_valid_in_2 (col_valid_in_2),
    .out_data_0     (out_data_0),
    .out_data_1     (out_data_1),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_last       (out_last),
    .busy           (busy),
    .done           (done),
    .fifo_count     (fifo_count),
    .err_align      (err_align),
    .err_overflow   (err_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Advance one clock. A row seen valid with ready held is accepted at the
  // coming edge, so it is scored here; done must follow one cycle later.
  task automatic step();
    logic acc;
    logic nxt_done;
    row_t exp;
    acc      = !rst && (out_valid === 1'b1) && (out_ready === 1'b1);
    nxt_done = 1'b0;
    if (acc) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_row got=%h/%h required=none", out_data_0, out_data_1);
      end else begin
        exp = sb.pop_front();
        if ({out_data_0, out_data_1, out_last} !== {exp.d0, exp.d1, exp.last}) begin
          bad++;
          $display("FAIL row got=%h/%h last=%b required=%h/%h last=%b",
                   out_data_0, out_data_1, out_last, exp.d0, exp.d1, exp.last);
        end
        nxt_done = exp.last;
      end
    end
    if (zero_start && !rst) nxt_done = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (done !== nxt_done) begin
      bad++;
      $display("FAIL done_pulse got=%b required=%b", done, nxt_done);
    end
  endtask

  task automatic start_job(input int rows);
    start      = 1'b1;
    cfg_rows   = 8'(rows);
    zero_start = (rows == 0);
    step();
    start      = 1'b0;
    zero_start = 1'b0;
  endtask

  // Stream n rows back to back (col2 one cycle behind col1); the first
  // 'keep' rows are expected out, the last kept one flagged last.
  task automatic send_rows(input int n, input int keep, input logic [15:0] base);
    for (int k = 0; k <= n; k++) begin
      col_valid_in_1 = (k < n);
      col_data_in_1  = base + 16'(k * 512);
      col_valid_in_2 = (k > 0);
      col_data_in_2  = base + 16'((k - 1) * 512 + 256);
      if (k > 0 && (k - 1) < keep)
        sb.push_back('{d0: base + 16'((k - 1) * 512), d1: base + 16'((k - 1) * 512 + 256),
                       last: ((k - 1) == keep - 1)});
      step();
    end
    col_valid_in_1 = 1'b0;
    col_valid_in_2 = 1'b0;
  endtask

  task automatic drain(output int left);
    out_ready = 1'b1;
    for (int i = 0; i < 40 && sb.size() > 0; i++) step();
    left = sb.size();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    total++;
    if ({out_data_0, out_data_1, out_valid, out_last, busy, done, fifo_count,
         err_align, err_overflow} !== 43'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h/%h v=%b cnt=%0d busy=%b required=all zero",
               out_data_0, out_data_1, out_valid, fifo_count, busy);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_identity();
    int left;
    out_ready = 1'b1;
    start_job(2);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL identity_busy got=%b required=1", busy); end
    send_rows(2, 2, 16'h0100);
    drain(left);
    total++;
    if (left !== 0) begin bad++; $display("FAIL identity_drain got=%0d required=0", left); end
    total++;
    if ({busy, err_align, err_overflow} !== 3'b000) begin
      bad++;
      $display("FAIL identity_flags got=%b%b%b required=000", busy, err_align, err_overflow);
    end
    step();
  endtask

  task automatic test_backpressure();
    int left;
    out_ready = 1'b0;
    start_job(4);
    send_rows(4, 4, 16'h2000);
    total++;
    if (fifo_count !== 4'd4) begin
      bad++;
      $display("FAIL bp_count got=%0d required=4", fifo_count);
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({out_valid, out_data_0, out_data_1} !== {1'b1, sb[0].d0, sb[0].d1}) begin
        bad++;
        $display("FAIL bp_hold got=%b %h/%h required=1 %h/%h",
                 out_valid, out_data_0, out_data_1, sb[0].d0, sb[0].d1);
      end
      step();
    end
    drain(left);
    total++;
    if (left !== 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL bp_drain got=left %0d busy %b required=0 0", left, busy);
    end
    step();
  endtask

  task automatic test_overflow();
    int left;
    out_ready = 1'b0;
    start_job(10);
    send_rows(10, 8, 16'h3000);
    total++;
    if (fifo_count !== 4'd8 || err_overflow !== 1'b1) begin
      bad++;
      $display("FAIL ovf_state got=cnt %0d err %b required=8 1", fifo_count, err_overflow);
    end
    drain(left);
    total++;
    if (left !== 0 || busy !== 1'b0 || fifo_count !== 4'd0) begin
      bad++;
      $display("FAIL ovf_drain got=left %0d busy %b cnt %0d required=0 0 0",
               left, busy, fifo_count);
    end
    step();
  endtask

  task automatic test_misalign();
    int left;
    out_ready = 1'b1;
    start_job(1);
    total++;
    if (err_overflow !== 1'b0) begin
      bad++;
      $display("FAIL start_clears_ovf got=%b required=0", err_overflow);
    end
    col_valid_in_2 = 1'b1;
    col_data_in_2  = 16'hdead;
    step();
    col_valid_in_2 = 1'b0;
    step();
    total++;
    if (err_align !== 1'b1 || fifo_count !== 4'd0) begin
      bad++;
      $display("FAIL align_col2 got=err %b cnt %0d required=1 0", err_align, fifo_count);
    end
    send_rows(1, 1, 16'h4000);
    drain(left);
    step();
    // Second case: two column-1 values without a column-2 partner.
    start_job(1);
    total++;
    if (err_align !== 1'b0) begin
      bad++;
      $display("FAIL start_clears_align got=%b required=0", err_align);
    end
    col_valid_in_1 = 1'b1;
    col_data_in_1  = 16'haaaa;
    step();
    col_data_in_1  = 16'h5555;
    step();
    col_valid_in_1 = 1'b0;
    col_valid_in_2 = 1'b1;
    col_data_in_2  = 16'h1234;
    sb.push_back('{d0: 16'h5555, d1: 16'h1234, last: 1'b1});
    step();
    col_valid_in_2 = 1'b0;
    total++;
    if (err_align !== 1'b1) begin
      bad++;
      $display("FAIL align_col1 got=%b required=1", err_align);
    end
    drain(left);
    total++;
    if (left !== 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL align_drain got=left %0d busy %b required=0 0", left, busy);
    end
    step();
  endtask

  task automatic test_edges();
    start_job(0);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL zero_rows_busy got=%b required=0", busy); end
    col_valid_in_1 = 1'b1;
    col_data_in_1  = 16'h7777;
    step();
    col_valid_in_2 = 1'b1;
    col_data_in_2  = 16'h8888;
    step();
    col_valid_in_1 = 1'b0;
    col_valid_in_2 = 1'b0;
    step();
    total++;
    if (fifo_count !== 4'd0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_valids got=cnt %0d v %b busy %b required=0 0 0",
               fifo_count, out_valid, busy);
    end
  endtask

  task automatic test_reset_midjob();
    int left;
    out_ready = 1'b0;
    start_job(5);
    send_rows(3, 3, 16'h5000);
    total++;
    if (fifo_count !== 4'd3 || busy !== 1'b1) begin
      bad++;
      $display("FAIL midjob_fill got=cnt %0d busy %b required=3 1", fifo_count, busy);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb.delete();
    total++;
    if ({out_data_0, out_data_1, out_valid, out_last, busy, done, fifo_count,
         err_align, err_overflow} !== 43'd0) begin
      bad++;
      $display("FAIL midjob_reset got=%h/%h v=%b cnt=%0d busy=%b required=all zero",
               out_data_0, out_data_1, out_valid, fifo_count, busy);
    end
    out_ready = 1'b1;
    start_job(2);
    send_rows(2, 2, 16'h6000);
    drain(left);
    total++;
    if (left !== 0 || busy !== 1'b0 || err_align !== 1'b0 || err_overflow !== 1'b0) begin
      bad++;
      $display("FAIL after_reset_job got=left %0d busy %b ea %b eo %b required=0 0 0 0",
               left, busy, err_align, err_overflow);
    end
    step();
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    zero_start     = 1'b0;
    rst            = 1'b1;
    start          = 1'b0;
    cfg_rows       = 8'd0;
    col_data_in_1  = 16'd0;
    col_valid_in_1 = 1'b0;
    col_data_in_2  = 16'd0;
    col_valid_in_2 = 1'b0;
    out_ready      = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_identity();
    test_backpressure();
    test_overflow();
    test_misalign();
    test_edges();
    test_reset_midjob();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
